// File: rtl/column_error_accumulator_pkg.sv
// Shared widths and FSM state type for the column error accumulator.
package ecomp_pkg;

  localparam int DEF_PSUM_W  = 24;
  localparam int DEF_EPROD_W = 16;
  localparam int DEF_ACC_W   = 32;

  typedef enum logic [0:0] {
    IDLE,
    ACCUM
  } state_e;

  // Tile index width; keeps a 1-bit field when only one beat forms a result.
  function automatic int tidx_w(input int num_tiles);
    return (num_tiles > 1) ? $clog2(num_tiles) : 1;
  endfunction

endpackage

// File: rtl/column_error_accumulator_if.sv
// Beat input and result output handshake bundle of the column error accumulator.
interface column_error_accumulator_if
  import ecomp_pkg::*;
#(
  parameter int PSUM_W  = DEF_PSUM_W,
  parameter int EPROD_W = DEF_EPROD_W,
  parameter int ACC_W   = DEF_ACC_W
) ();

  logic               in_valid;
  logic               in_ready;
  logic [PSUM_W-1:0]  partial_sum_in;
  logic [EPROD_W-1:0] error_prod_in;
  logic               error_in;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   result_out;

  modport master (
    output in_valid, partial_sum_in, error_prod_in, error_in, out_ready,
    input  in_ready, out_valid, result_out
  );

  modport slave (
    input  in_valid, partial_sum_in, error_prod_in, error_in, out_ready,
    output in_ready, out_valid, result_out
  );

endinterface

// File: rtl/column_error_accumulator_out_fifo.sv
// Synchronous output FIFO for column results; head reads as zero while empty.
module ecomp_out_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/column_error_accumulator.sv
// Applies deferred error compensation, sums NUM_TILES beats per column result, queues results.
// Optional ECOMP_ERR_COUNT_EN adds a saturating count of accepted beats with a pending error.
module column_error_accumulator
  import ecomp_pkg::*;
#(
  parameter int PSUM_W     = DEF_PSUM_W,
  parameter int EPROD_W    = DEF_EPROD_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int NUM_TILES  = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int TIDX_W    = tidx_w(NUM_TILES)
) (
  input  logic                clk,
  input  logic                rst_n,
  column_error_accumulator_if.slave bus,
  output logic [TIDX_W-1:0]   tile_idx
`ifdef ECOMP_ERR_COUNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [TIDX_W-1:0]   tile_q, tile_d;
  logic [ACC_W-1:0]    corrected, sum;
  logic                fifo_full, accept, last_beat, push;

  assign bus.in_ready = !fifo_full;
  assign accept       = bus.in_valid && !fifo_full;
  assign corrected    = ACC_W'(bus.partial_sum_in)
                      + (bus.error_in ? ACC_W'(bus.error_prod_in) : '0);
  assign sum          = acc_q + corrected;
  assign last_beat    = (tile_q == TIDX_W'(NUM_TILES - 1));
  assign tile_idx     = tile_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tile_d  = tile_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (last_beat) begin
            push = 1'b1;
          end else begin
            acc_d   = corrected;
            tile_d  = TIDX_W'(1);
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (last_beat) begin
            push    = 1'b1;
            acc_d   = '0;
            tile_d  = '0;
            state_d = IDLE;
          end else begin
            acc_d  = sum;
            tile_d = tile_q + TIDX_W'(1);
          end
        end
      end
      default: begin
        acc_d   = '0;
        tile_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tile_q  <= tile_d;
    end
  end

  // In IDLE acc_q is zero, so sum is the single corrected beat when NUM_TILES==1.
  ecomp_out_fifo #(
    .W     (ACC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (sum),
    .pop_i   (bus.out_ready),
    .data_o  (bus.result_out),
    .valid_o (bus.out_valid),
    .full_o  (fifo_full)
  );

`ifdef ECOMP_ERR_COUNT_EN
  logic [15:0] errc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      errc_q <= '0;
    end else if (accept && bus.error_in && (errc_q != 16'hFFFF)) begin
      errc_q <= errc_q + 16'd1;
    end
  end

  assign err_count = errc_q;
`endif

endmodule
